// File: rtl/rom_burst_reader.sv
// rom_burst_reader: fixed lookup table with a burst read engine.
// Streams consecutive words over valid/ready, wrapping modulo DEPTH.
module rom_burst_reader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   burst_len,
   input  logic              abort,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] TWO_L   = (ADDR_W+1)'(2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   data_d;
   logic [DATA_W-1:0]   start_data;
   logic [ADDR_W:0]     rem_q;
   logic                valid_q;
   logic                last_q;
   logic                done_q;
   logic                err_q;
   logic                hs;
   logic                len_ok;

   // Table lookup: base pattern repeats every 8 words, resized to DATA_W
   function automatic logic [DATA_W-1:0] rom_word(
      input logic [ADDR_W-1:0] a
   );
      logic [2:0]  idx;
      logic [15:0] t;
      idx = 3'(a);
      case (idx)
         3'd0:    t = 16'hAAAA;
         3'd1:    t = 16'hABCD;
         3'd2:    t = 16'h9999;
         3'd3:    t = 16'h2121;
         3'd4:    t = 16'h8585;
         3'd5:    t = 16'h4258;
         3'd6:    t = 16'h7B4E;
         default: t = 16'h9A2B;
      endcase
      return DATA_W'(t);
   endfunction

   // Next word to present after a handshake, and the first word of a burst
   always_comb begin
      addr_d     = addr_q + ADDR_W'(1);
      data_d     = rom_word(addr_d);
      start_data = rom_word(start_addr);
      hs         = valid_q & out_ready;
      len_ok     = (burst_len != '0) && (burst_len <= DEPTH_L);
   end

   // Burst control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     state_q <= STREAM;
                     addr_q  <= start_addr;
                     data_q  <= start_data;
                     rem_q   <= burst_len;
                     valid_q <= 1'b1;
                     last_q  <= (burst_len == ONE_L);
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (abort) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end else if (hs) begin
                  if (rem_q == ONE_L) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= addr_d;
                     data_q <= data_d;
                     rem_q  <= rem_q - ONE_L;
                     last_q <= (rem_q == TWO_L);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_data  = data_q;
   assign out_addr  = addr_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed checks of rom_burst_reader in three
// parameter configurations (16x8, 8x16, 24x8).
module tb_rom_burst_reader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] T [8] = '{16'hAAAA, 16'hABCD, 16'h9999, 16'h2121,
                          16'h8585, 16'h4258, 16'h7B4E, 16'h9A2B};

   // DUT A: DATA_W=16, ADDR_W=3
   logic        a_start = 0, a_abort = 0, a_ready = 0;
   logic [2:0]  a_addr = 0;
   logic [3:0]  a_len = 0;
   logic [15:0] a_data;
   logic [2:0]  a_oaddr;
   logic        a_valid, a_last, a_busy, a_done, a_err;

   // DUT B: DATA_W=8, ADDR_W=4
   logic        b_start = 0, b_abort = 0, b_ready = 0;
   logic [3:0]  b_addr = 0;
   logic [4:0]  b_len = 0;
   logic [7:0]  b_data;
   logic [3:0]  b_oaddr;
   logic        b_valid, b_last, b_busy, b_done, b_err;

   // DUT C: DATA_W=24, ADDR_W=3
   logic        c_start = 0, c_abort = 0, c_ready = 0;
   logic [2:0]  c_addr = 0;
   logic [3:0]  c_len = 0;
   logic [23:0] c_data;
   logic [2:0]  c_oaddr;
   logic        c_valid, c_last, c_busy, c_done, c_err;

   rom_burst_reader #(.DATA_W(16), .ADDR_W(3)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .start_addr(a_addr),
      .burst_len(a_len), .abort(a_abort), .out_data(a_data),
      .out_addr(a_oaddr), .out_valid(a_valid), .out_ready(a_ready),
      .out_last(a_last), .busy(a_busy), .done(a_done), .err(a_err));

   rom_burst_reader #(.DATA_W(8), .ADDR_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .start_addr(b_addr),
      .burst_len(b_len), .abort(b_abort), .out_data(b_data),
      .out_addr(b_oaddr), .out_valid(b_valid), .out_ready(b_ready),
      .out_last(b_last), .busy(b_busy), .done(b_done), .err(b_err));

   rom_burst_reader #(.DATA_W(24), .ADDR_W(3)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .start_addr(c_addr),
      .burst_len(c_len), .abort(c_abort), .out_data(c_data),
      .out_addr(c_oaddr), .out_valid(c_valid), .out_ready(c_ready),
      .out_last(c_last), .busy(c_busy), .done(c_done), .err(c_err));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full burst on DUT A with out_ready held high
   task automatic run_burst(input int sa, input int len);
      int ea;
      a_ready = 1;
      a_start = 1;
      a_addr  = 3'(sa);
      a_len   = 4'(len);
      tick();
      a_start = 0;
      a_addr  = 3'd0;
      a_len   = 4'd0;
      for (int i = 0; i < len; i++) begin
         ea = (sa + i) % 8;
         chk("burst_valid", 32'(a_valid), 32'd1);
         chk("burst_addr", 32'(a_oaddr), 32'(ea));
         chk("burst_data", 32'(a_data), 32'(T[ea]));
         chk("burst_last", 32'(a_last), 32'(i == len - 1));
         chk("burst_busy", 32'(a_busy), 32'd1);
         chk("burst_nodone", 32'(a_done), 32'd0);
         tick();
      end
      chk("end_valid", 32'(a_valid), 32'd0);
      chk("end_last", 32'(a_last), 32'd0);
      chk("end_done", 32'(a_done), 32'd1);
      chk("end_busy", 32'(a_busy), 32'd1);
      tick();
      chk("idle_done", 32'(a_done), 32'd0);
      chk("idle_busy", 32'(a_busy), 32'd0);
   endtask

   initial begin
      logic [15:0] exp3 [3];
      logic        pat [6];
      int          k;
      int          nhs;
      exp3 = '{16'h9999, 16'h2121, 16'h8585};
      pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state
      tick();
      tick();
      chk("rst_data", 32'(a_data), 32'd0);
      chk("rst_addr", 32'(a_oaddr), 32'd0);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_last", 32'(a_last), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_err", 32'(a_err), 32'd0);
      rst_n = 1;
      tick();

      // Full table read and wrap-around
      run_burst(0, 8);
      run_burst(6, 4);

      // Stalled burst with out_ready pattern 1,0,0,1,0,1
      a_start = 1;
      a_addr  = 3'd2;
      a_len   = 4'd3;
      a_ready = pat[0];
      tick();
      a_start = 0;
      k = 0;
      nhs = 0;
      for (int i = 0; i < 6; i++) begin
         a_ready = pat[i];
         chk("stall_valid", 32'(a_valid), 32'd1);
         chk("stall_data", 32'(a_data), 32'(exp3[k]));
         chk("stall_addr", 32'(a_oaddr), 32'(2 + k));
         chk("stall_last", 32'(a_last), 32'(k == 2));
         if (a_ready && a_valid) begin
            k++;
            nhs++;
         end
         tick();
      end
      chk("stall_hs", 32'(nhs), 32'd3);
      chk("stall_done", 32'(a_done), 32'd1);
      chk("stall_valid0", 32'(a_valid), 32'd0);
      tick();
      chk("stall_done1", 32'(a_done), 32'd0);

      // Illegal lengths 0 and 9
      a_start = 1;
      a_addr  = 3'd1;
      a_len   = 4'd0;
      tick();
      a_start = 0;
      chk("err0", 32'(a_err), 32'd1);
      chk("err0_valid", 32'(a_valid), 32'd0);
      chk("err0_busy", 32'(a_busy), 32'd0);
      tick();
      chk("err0_pulse", 32'(a_err), 32'd0);
      a_start = 1;
      a_len   = 4'd9;
      tick();
      a_start = 0;
      chk("err9", 32'(a_err), 32'd1);
      chk("err9_valid", 32'(a_valid), 32'd0);
      chk("err9_busy", 32'(a_busy), 32'd0);
      tick();
      chk("err9_pulse", 32'(a_err), 32'd0);

      // Start during a legal burst is ignored
      a_ready = 0;
      a_start = 1;
      a_addr  = 3'd0;
      a_len   = 4'd2;
      tick();
      a_addr  = 3'd5;
      a_len   = 4'd1;
      tick();
      a_start = 0;
      chk("ign_addr", 32'(a_oaddr), 32'd0);
      chk("ign_data", 32'(a_data), 32'hAAAA);
      chk("ign_err", 32'(a_err), 32'd0);
      chk("ign_last", 32'(a_last), 32'd0);
      a_ready = 1;
      tick();
      chk("ign_data2", 32'(a_data), 32'hABCD);
      chk("ign_last2", 32'(a_last), 32'd1);
      tick();
      chk("ign_done", 32'(a_done), 32'd1);
      tick();

      // Abort after two accepted words
      a_start = 1;
      a_addr  = 3'd0;
      a_len   = 4'd8;
      tick();
      a_start = 0;
      tick();
      tick();
      chk("ab_pre_data", 32'(a_data), 32'h9999);
      a_abort = 1;
      tick();
      a_abort = 0;
      chk("ab_valid", 32'(a_valid), 32'd0);
      chk("ab_done", 32'(a_done), 32'd0);
      chk("ab_busy", 32'(a_busy), 32'd0);
      tick();
      chk("ab_done2", 32'(a_done), 32'd0);
      a_start = 1;
      a_addr  = 3'd5;
      a_len   = 4'd1;
      tick();
      a_start = 0;
      chk("ab_new_data", 32'(a_data), 32'h4258);
      chk("ab_new_last", 32'(a_last), 32'd1);
      chk("ab_new_valid", 32'(a_valid), 32'd1);
      tick();
      chk("ab_new_done", 32'(a_done), 32'd1);
      tick();

      // Asynchronous reset mid-burst
      a_start = 1;
      a_addr  = 3'd3;
      a_len   = 4'd8;
      tick();
      a_start = 0;
      tick();
      #2;
      rst_n = 0;
      #1;
      chk("ar_data", 32'(a_data), 32'd0);
      chk("ar_addr", 32'(a_oaddr), 32'd0);
      chk("ar_valid", 32'(a_valid), 32'd0);
      chk("ar_last", 32'(a_last), 32'd0);
      chk("ar_busy", 32'(a_busy), 32'd0);
      chk("ar_done", 32'(a_done), 32'd0);
      chk("ar_err", 32'(a_err), 32'd0);
      tick();
      rst_n = 1;
      tick();
      run_burst(0, 8);

      // DATA_W=8, ADDR_W=4
      b_ready = 1;
      b_start = 1;
      b_addr  = 4'd15;
      b_len   = 5'd3;
      tick();
      b_start = 0;
      chk("b_d15", 32'(b_data), 32'h2B);
      chk("b_a15", 32'(b_oaddr), 32'd15);
      chk("b_l15", 32'(b_last), 32'd0);
      tick();
      chk("b_d0", 32'(b_data), 32'hAA);
      chk("b_a0", 32'(b_oaddr), 32'd0);
      tick();
      chk("b_d1", 32'(b_data), 32'hCD);
      chk("b_a1", 32'(b_oaddr), 32'd1);
      chk("b_l1", 32'(b_last), 32'd1);
      tick();
      chk("b_done", 32'(b_done), 32'd1);
      tick();
      b_start = 1;
      b_addr  = 4'd9;
      b_len   = 5'd1;
      tick();
      b_start = 0;
      chk("b_d9", 32'(b_data), 32'hCD);
      chk("b_l9", 32'(b_last), 32'd1);
      tick();
      tick();
      b_start = 1;
      b_len   = 5'd17;
      tick();
      b_start = 0;
      chk("b_err17", 32'(b_err), 32'd1);
      chk("b_err17_valid", 32'(b_valid), 32'd0);
      tick();
      b_start = 1;
      b_addr  = 4'd2;
      b_len   = 5'd16;
      tick();
      b_start = 0;
      chk("b_len16_valid", 32'(b_valid), 32'd1);
      chk("b_len16_err", 32'(b_err), 32'd0);
      b_abort = 1;
      tick();
      b_abort = 0;
      chk("b_abort", 32'(b_valid), 32'd0);
      tick();

      // DATA_W=24 zero-extension
      c_ready = 1;
      c_start = 1;
      c_addr  = 3'd3;
      c_len   = 4'd1;
      tick();
      c_start = 0;
      chk("c_d3", 32'(c_data), 32'h002121);
      tick();
      tick();
      c_start = 1;
      c_addr  = 3'd7;
      c_len   = 4'd1;
      tick();
      c_start = 0;
      chk("c_d7", 32'(c_data), 32'h009A2B);
      chk("c_l7", 32'(c_last), 32'd1);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
